// File: rtl/enduro_sync_ram_if.sv
// Bus bundle for enduro_sync_ram: one byte-enabled write port, one read port
// with valid pulse, and the init-busy status flag.
interface enduro_sync_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_busy;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/enduro_sync_ram.sv
// Single-clock simple dual-port RAM with byte enables, 1- or 2-cycle registered
// read, selectable read-during-write behaviour and a post-reset clear engine.
module enduro_sync_ram #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    MEM_DEPTH   = 64,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    WRITE_FIRST = 1,
  parameter int                    DO_INIT     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input logic               clk,
  input logic               rst,
  enduro_sync_ram_if.slave  bus
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("enduro_sync_ram: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("enduro_sync_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("enduro_sync_ram: MEM_DEPTH exceeds 2**ADDR_WIDTH");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  init_last;
  logic                  init_we;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_in_range;
  logic                  collide;
  logic [DATA_WIDTH-1:0] be_mask;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;

  assign init_last   = (32'(init_addr) == 32'(MEM_DEPTH - 1));
  assign init_we     = !rst && (state == INIT);
  assign wr_ok       = !rst && (state == READY) && bus.wr_en &&
                       (32'(bus.wr_addr) < 32'(MEM_DEPTH));
  assign rd_ok       = (state == READY) && bus.rd_en;
  assign rd_in_range = (32'(bus.rd_addr) < 32'(MEM_DEPTH));
  assign collide     = wr_ok && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= (DO_INIT != 0) ? INIT : READY;
      bus.init_busy <= (DO_INIT != 0);
      init_addr     <= '0;
    end else if (state == INIT) begin
      init_addr <= init_addr + 1'b1;
      if (init_last) begin
        state         <= READY;
        bus.init_busy <= 1'b0;
      end
    end
  end

  // The array has no reset; only the init engine or a granted write touches it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VALUE;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      be_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.wr_be[i]}};
    end
  end

  assign merged = (mem[bus.rd_addr] & ~be_mask) | (bus.wr_data & be_mask);

  // Write-first collisions see the merged word; otherwise the pre-edge contents.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((WRITE_FIRST != 0) && collide) begin
        rd_word = merged;
      end else begin
        rd_word = mem[bus.rd_addr];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid     <= 1'b0;
        s1_data      <= '0;
        bus.rd_valid <= 1'b0;
        bus.rd_data  <= '0;
      end else begin
        s1_valid     <= rd_ok;
        bus.rd_valid <= s1_valid;
        if (rd_ok) begin
          s1_data <= rd_word;
        end
        if (s1_valid) begin
          bus.rd_data <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bus.rd_valid <= 1'b0;
        bus.rd_data  <= '0;
      end else begin
        bus.rd_valid <= rd_ok;
        if (rd_ok) begin
          bus.rd_data <= rd_word;
        end
      end
    end
  end
endmodule

// File: tb/tb_enduro_sync_ram.sv
// Directed bench for enduro_sync_ram: instance a is the default configuration,
// instance b is depth 48, two-cycle read latency and read-first collisions.
module tb_enduro_sync_ram;
  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [5:0]  rd_addr;

  int checks;
  int errors;

  enduro_sync_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) a_if ();
  enduro_sync_ram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) b_if ();

  assign a_if.wr_en   = wr_en;
  assign a_if.wr_addr = wr_addr;
  assign a_if.wr_be   = wr_be;
  assign a_if.wr_data = wr_data;
  assign a_if.rd_en   = rd_en;
  assign a_if.rd_addr = rd_addr;
  assign b_if.wr_en   = wr_en;
  assign b_if.wr_addr = wr_addr;
  assign b_if.wr_be   = wr_be;
  assign b_if.wr_data = wr_data;
  assign b_if.rd_en   = rd_en;
  assign b_if.rd_addr = rd_addr;

  enduro_sync_ram #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .MEM_DEPTH(64),
    .RD_LATENCY(1), .WRITE_FIRST(1), .DO_INIT(1), .INIT_VALUE(32'h0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if)
  );

  enduro_sync_ram #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .MEM_DEPTH(48),
    .RD_LATENCY(2), .WRITE_FIRST(0), .DO_INIT(1), .INIT_VALUE(32'h0)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input logic [5:0] wa, input logic [3:0] be, input logic [31:0] wd);
    wr_en   = 1'b1;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    step();
    wr_en = 1'b0;
  endtask

  // One read (optionally with a same-cycle write); a answers after one edge, b after two.
  task automatic applyStimulus(input logic we, input logic [5:0] wa, input logic [3:0] be,
                               input logic [31:0] wd, input logic [5:0] ra,
                               input logic [31:0] exp_a, input logic [31:0] exp_b);
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    rd_en   = 1'b1;
    rd_addr = ra;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checkOutput($sformatf("a_valid@%0d", ra), 32'(a_if.rd_valid), 32'd1);
    checkOutput($sformatf("a_data@%0d", ra), a_if.rd_data, exp_a);
    checkOutput($sformatf("b_valid_early@%0d", ra), 32'(b_if.rd_valid), 32'd0);
    step();
    checkOutput($sformatf("a_valid_pulse@%0d", ra), 32'(a_if.rd_valid), 32'd0);
    checkOutput($sformatf("a_data_hold@%0d", ra), a_if.rd_data, exp_a);
    checkOutput($sformatf("b_valid@%0d", ra), 32'(b_if.rd_valid), 32'd1);
    checkOutput($sformatf("b_data@%0d", ra), b_if.rd_data, exp_b);
  endtask

  task automatic readWord(input logic [5:0] ra, input logic [31:0] exp_a, input logic [31:0] exp_b);
    applyStimulus(1'b0, 6'd0, 4'h0, 32'h0, ra, exp_a, exp_b);
  endtask

  // Holds rd_en high through init and counts busy cycles of both instances.
  task automatic countInit(input int exp_a, input int exp_b);
    int cnt_a;
    int cnt_b;
    cnt_a   = 0;
    cnt_b   = 0;
    rd_en   = 1'b1;
    rd_addr = 6'd0;
    while (a_if.init_busy === 1'b1 && cnt_a < 200) begin
      cnt_a++;
      checkOutput("init_rd_valid_a", 32'(a_if.rd_valid), 32'd0);
      if (b_if.init_busy === 1'b1) begin
        cnt_b++;
        checkOutput("init_rd_valid_b", 32'(b_if.rd_valid), 32'd0);
      end
      step();
    end
    checkOutput("init_cycles_a", 32'(cnt_a), 32'(exp_a));
    checkOutput("init_cycles_b", 32'(cnt_b), 32'(exp_b));
    rd_en = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_en   = 1'b1;
    rd_addr = '0;
    #1;
    checkOutput("reset_rd_data_a", a_if.rd_data, 32'h0);
    checkOutput("reset_rd_valid_a", 32'(a_if.rd_valid), 32'd0);
    checkOutput("reset_busy_a", 32'(a_if.init_busy), 32'd1);
    checkOutput("reset_busy_b", 32'(b_if.init_busy), 32'd1);
    step();
    step();
    rst = 1'b0;
    $display("[TB] init after power-up reset");
    countInit(64, 48);

    for (int i = 0; i < 64; i++) begin
      readWord(6'(i), 32'h0, 32'h0);
    end

    $display("[TB] byte enables");
    writeWord(6'd5, 4'b1111, 32'hAABBCCDD);
    writeWord(6'd5, 4'b0010, 32'h11223344);
    readWord(6'd5, 32'hAABB33DD, 32'hAABB33DD);
    writeWord(6'd5, 4'b0000, 32'hFFFFFFFF);
    readWord(6'd5, 32'hAABB33DD, 32'hAABB33DD);

    $display("[TB] collisions");
    applyStimulus(1'b1, 6'd7, 4'b1111, 32'hDEADBEEF, 6'd7, 32'hDEADBEEF, 32'h00000000);
    readWord(6'd7, 32'hDEADBEEF, 32'hDEADBEEF);
    writeWord(6'd9, 4'b1111, 32'h11111111);
    applyStimulus(1'b1, 6'd9, 4'b0101, 32'hAAAAAAAA, 6'd9, 32'h11AA11AA, 32'h11111111);
    readWord(6'd9, 32'h11AA11AA, 32'h11AA11AA);
    applyStimulus(1'b1, 6'd10, 4'b1111, 32'h0A0A0A0A, 6'd5, 32'hAABB33DD, 32'hAABB33DD);
    readWord(6'd10, 32'h0A0A0A0A, 32'h0A0A0A0A);

    $display("[TB] depth boundary");
    writeWord(6'd50, 4'b1111, 32'h12345678);
    readWord(6'd50, 32'h12345678, 32'h0);
    writeWord(6'd48, 4'b1111, 32'hCAFEF00D);
    readWord(6'd48, 32'hCAFEF00D, 32'h0);
    writeWord(6'd47, 4'b1111, 32'h47474747);
    readWord(6'd47, 32'h47474747, 32'h47474747);
    readWord(6'd2, 32'h0, 32'h0);
    readWord(6'd0, 32'h0, 32'h0);
    readWord(6'd63, 32'h0, 32'h0);
    applyStimulus(1'b1, 6'd60, 4'b1111, 32'h60606060, 6'd60, 32'h60606060, 32'h0);

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 64; i++) begin
      writeWord(6'(i), 4'b1111, 32'(i));
    end
    step();
    step();
    rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      step();
      checkOutput($sformatf("stream_a_valid@%0d", i), 32'(a_if.rd_valid), 32'd1);
      checkOutput($sformatf("stream_a_data@%0d", i), a_if.rd_data, 32'(i));
      checkOutput($sformatf("stream_b_valid@%0d", i), 32'(b_if.rd_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("stream_b_data@%0d", i - 1), b_if.rd_data, (i - 1 < 48) ? 32'(i - 1) : 32'h0);
      end
    end
    rd_en = 1'b0;
    step();
    checkOutput("stream_a_valid_end", 32'(a_if.rd_valid), 32'd0);
    checkOutput("stream_a_data_hold", a_if.rd_data, 32'd63);
    checkOutput("stream_b_valid@63", 32'(b_if.rd_valid), 32'd1);
    checkOutput("stream_b_data@63", b_if.rd_data, 32'h0);
    step();
    checkOutput("stream_b_valid_end", 32'(b_if.rd_valid), 32'd0);

    $display("[TB] asynchronous reset while ready");
    rd_en   = 1'b1;
    rd_addr = 6'd20;
    step();
    rd_en = 1'b0;
    checkOutput("pre_reset_a_valid", 32'(a_if.rd_valid), 32'd1);
    checkOutput("pre_reset_a_data", a_if.rd_data, 32'd20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_a_data", a_if.rd_data, 32'h0);
    checkOutput("async_rst_a_valid", 32'(a_if.rd_valid), 32'd0);
    checkOutput("async_rst_a_busy", 32'(a_if.init_busy), 32'd1);
    checkOutput("async_rst_b_data", b_if.rd_data, 32'h0);
    step();
    checkOutput("rst_held_b_valid", 32'(b_if.rd_valid), 32'd0);
    rst = 1'b0;

    $display("[TB] reset during init");
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    checkOutput("mid_init_busy", 32'(a_if.init_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_init_rst_busy", 32'(a_if.init_busy), 32'd1);
    checkOutput("mid_init_rst_valid", 32'(a_if.rd_valid), 32'd0);
    checkOutput("mid_init_rst_data", a_if.rd_data, 32'h0);
    step();
    rst = 1'b0;
    countInit(64, 48);
    for (int i = 0; i < 64; i++) begin
      readWord(6'(i), 32'h0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/enduro_sync_ram.md
Name: enduro_sync_ram

Overview:
Single-clock simple dual-port RAM (one write port, one read port). It adds byte-enable writes, a registered read path with selectable latency and rd_valid, and a read-during-write collision mode. A sequential init engine clears the array after reset. It is the next-generation storage primitive for synchronous FIFOs and buffers in the enduro FIFO family, and supports non-power-of-two depths.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 6, address bits
MEM_DEPTH, 64, number of words; must satisfy MEM_DEPTH <= 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in clock edges; legal values 1 or 2
WRITE_FIRST, 1, collision mode: 1 returns the new (merged) word, 0 returns the old word
DO_INIT, 1, 1 enables the post-reset sequential clear; 0 means memory comes up uninitialised
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during init

Ports:
clk  input  1  single clock; all logic rises on posedge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_be  input  NUM_BYTES  byte enables; bit i selects wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse per accepted read
init_busy  output  1  high while the init engine owns the array

Behaviour:
- Reset is asynchronous and active-high. While rst=1: rd_data=0, rd_valid=0, all read pipeline stages cleared, init_addr=0, and the FSM is in INIT (DO_INIT=1) or READY (DO_INIT=0). init_busy=1 in INIT, 0 in READY. Array contents are not cleared by rst itself.
- FSM has two states, INIT and READY.
  - In INIT, each edge writes INIT_VALUE to mem[init_addr] and increments init_addr.
  - The edge that writes MEM_DEPTH-1 moves the FSM to READY. init_busy therefore stays high for exactly MEM_DEPTH cycles after rst deasserts.
  - READY is terminal until the next rst.
  - rst asserted mid-INIT restarts init from address 0.
- While in INIT, wr_en and rd_en are ignored: no array write, no rd_valid.
- Write (READY): at the edge with wr_en=1 and wr_addr<MEM_DEPTH, only the byte lanes with wr_be=1 are updated. wr_be=0 leaves the word unchanged. wr_addr>=MEM_DEPTH drops the write silently.
- Read (READY): rd_en=1 is sampled at edge N.
  - RD_LATENCY=1: rd_data and rd_valid update at edge N.
  - RD_LATENCY=2: they update at edge N+1.
  - Full throughput: one read per cycle, in order.
  - rd_valid is high for one cycle per read. rd_data holds its last value when no read completes.
  - rd_addr>=MEM_DEPTH returns 0 with rd_valid=1.
- Collision: rd_en and wr_en in the same cycle at the same in-range address.
  - WRITE_FIRST=1 returns the merged word: wr_data on enabled lanes, old data on the others.
  - WRITE_FIRST=0 returns the pre-write word.
  - The array always takes the write.
- Different addresses in the same cycle are independent.
- Illegal parameter combinations (RD_LATENCY not 1 or 2, DATA_WIDTH not a multiple of BYTE_WIDTH, MEM_DEPTH > 2**ADDR_WIDTH) must trigger an elaboration-time $error.

Test Plan:
1. DO_INIT=1, MEM_DEPTH=64, rst released -> init_busy high exactly 64 cycles. rd_en held high during init gives rd_valid=0. Afterwards a read of every address 0..63 returns 0x00000000.
2. Write 0xAABBCCDD, wr_be=4'b1111 to addr 5, then 0x11223344 with wr_be=4'b0010 -> read addr 5 returns 0xAABB33DD. rd_valid appears 1 edge after rd_en (RD_LATENCY=1) or 2 edges after (RD_LATENCY=2).
3. Addr 7 holds 0, then write 0xDEADBEEF (full be) and read addr 7 in the same cycle -> WRITE_FIRST=1 returns 0xDEADBEEF, WRITE_FIRST=0 returns 0x00000000. A following read returns 0xDEADBEEF in both modes.
4. MEM_DEPTH=48, ADDR_WIDTH=6: write 0x12345678 to addr 50 -> dropped. A read of addr 50 returns 0 with rd_valid=1, and addresses 0..47 are unchanged.
5. Assert rst at init cycle 20 -> rd_data=0 and rd_valid=0 immediately, without waiting for a clock edge. After release, init_busy is high for a full 64 cycles and the array reads back as 0.
6. RD_LATENCY=2: 64 back-to-back reads of addresses 0..63 after writing data=addr -> rd_valid is continuously high for 64 cycles and the data returns 0..63 in order.
